// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-pipeline constants: default address/instruction widths, reset PC and NOP encoding.
package inst_fetch_unit_pkg;
    localparam int          ADDR_W_DEF   = 32;
    localparam int          INST_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0000;
endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch bus: instruction-memory request/response, redirect from ID, and IF/ID valid/ready handshake.
interface inst_fetch_unit_if
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [INST_W-1:0] if_inst;
    logic [ADDR_W-1:0] if_pc4;

    modport master (
        output imem_req, imem_addr, if_valid, if_inst, if_pc4,
        input  imem_rdata, redirect, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_inst, if_pc4,
        output imem_rdata, redirect, redirect_pc, if_ready
    );
endinterface

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Circular prefetch FIFO of DEPTH entries with wrapping pointers, occupancy count and synchronous clear.
module inst_fetch_unit_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       pushData,
    output logic [WIDTH-1:0]       headData,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + PW'(1);
            if (pop)
                rdPtr <= rdPtr + PW'(1);
            if (push && !pop)
                count <= count + (PW+1)'(1);
            else if (pop && !push)
                count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wrPtr] <= pushData;
    end

    assign headData = mem[rdPtr];
endmodule

// File: rtl/inst_fetch_unit.sv
// IF stage: PC register, one-cycle-latency imem request port, prefetch queue feeding IF/ID.
// Optional FETCH_STATS_EN adds saturating stall/flush counters.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_unit_if.master  bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        stat_stall,
    output logic [15:0]        stat_flush
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INST_W + ADDR_W;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] reqAddr;
    logic              pending;
    logic              kill;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inFlight;
    logic              issue;
    logic              push;
    logic              pop;
    logic [EW-1:0]     headData;

    // Reserving a slot for every outstanding request means a response can never find the queue full
    assign inFlight = count + CW'(pending);
    assign issue    = rst && !bus.redirect && (inFlight < CW'(DEPTH));
    assign push     = pending && !kill;
    assign pop      = bus.if_valid && bus.if_ready && !bus.redirect;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign bus.if_valid  = (count != '0);
    assign bus.if_inst   = bus.if_valid ? headData[EW-1 -: INST_W] : INST_W'(NOP);
    assign bus.if_pc4    = bus.if_valid ? headData[ADDR_W-1:0]    : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            reqAddr <= '0;
            pending <= 1'b0;
            kill    <= 1'b0;
        end else begin
            pending <= issue;
            kill    <= bus.redirect && pending;
            if (bus.redirect)
                pc <= bus.redirect_pc;
            else if (issue)
                pc <= pc + ADDR_W'(4);
            if (issue)
                reqAddr <= pc;
        end
    end

    inst_fetch_unit_fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.redirect),
        .push     (push),
        .pop      (pop),
        .pushData ({bus.imem_rdata, reqAddr + ADDR_W'(4)}),
        .headData (headData),
        .count    (count)
    );

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_stall <= '0;
            stat_flush <= '0;
        end else begin
            if (bus.if_valid && !bus.if_ready && (stat_stall != '1))
                stat_stall <= stat_stall + 32'd1;
            if (bus.redirect && (stat_flush != '1))
                stat_flush <= stat_flush + 16'd1;
        end
    end
`endif
endmodule
